// File: rtl/delay_mon_pkg.sv
// Shared types for the delay capture monitor: FSM states and the result record.
package delay_mon_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {IDLE, WAIT, SETTLE, REPORT} state_t;

  // Result record at the default widths; the top builds the same layout at its own widths.
  typedef struct packed {
    logic [DEF_CNT_W-1:0]  delay;
    logic                  pass;
    logic                  timeout;
    logic [DEF_DATA_W-1:0] value;
  } res_t;

  function automatic int res_w(input int data_w, input int cnt_w);
    return cnt_w + 2 + data_w;
  endfunction

  localparam int RES_W = res_w(DEF_DATA_W, DEF_CNT_W);
endpackage

// File: rtl/delay_capture_monitor_if.sv
// Result port of the delay capture monitor: valid/ready handshake plus the measurement record.
interface delay_capture_monitor_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              res_valid_o;
  logic              res_ready_i;
  logic [CNT_W-1:0]  res_delay_o;
  logic              res_pass_o;
  logic              res_timeout_o;
  logic [DATA_W-1:0] res_value_o;

  modport master (
    output res_valid_o, res_delay_o, res_pass_o, res_timeout_o, res_value_o,
    input  res_ready_i
  );

  modport slave (
    input  res_valid_o, res_delay_o, res_pass_o, res_timeout_o, res_value_o,
    output res_ready_i
  );
endinterface

// File: rtl/delay_capture_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                      cnt_d = '0;
    else if (inc_i && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/delay_capture_monitor.sv
// Measures cycles from start_i until observed_i holds expected for SETTLE_CYCLES, with timeout.
// Optional DELAY_MON_STATS_EN adds accepted-result statistics ports.
module delay_capture_monitor
  import delay_mon_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int CNT_W         = 8,
  parameter int MAX_CYCLES    = 200,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] expected_i,
  input  logic [DATA_W-1:0] observed_i,
  output logic              busy_o,
  delay_capture_monitor_if.master res
`ifdef DELAY_MON_STATS_EN
  ,
  output logic [15:0]       stat_cnt_o,
  output logic [CNT_W-1:0]  stat_min_o,
  output logic [CNT_W-1:0]  stat_max_o,
  output logic [15:0]       stat_fail_o
`endif
);
  localparam int MW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

  typedef struct packed {
    logic [CNT_W-1:0]  delay;
    logic              pass;
    logic              timeout;
    logic [DATA_W-1:0] value;
  } res_rec_t;

  state_t            state_q, state_d;
  res_rec_t          res_q, res_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [CNT_W-1:0]  first_match_q, first_match_d;
  logic [CNT_W-1:0]  cnt;
  logic [MW-1:0]     match_cnt;
  logic              match, measuring, settle_done, timed_out, accept;
  logic              cnt_clr, cnt_inc, mcnt_clr, mcnt_inc;

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(cnt_clr), .inc_i(cnt_inc), .cnt_o(cnt)
  );

  sat_counter #(.W(MW)) u_match_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(mcnt_clr), .inc_i(mcnt_inc), .cnt_o(match_cnt)
  );

  // X/Z on the observed bus must never count as a match.
  assign match       = (observed_i === exp_q);
  assign measuring   = (state_q == WAIT) || (state_q == SETTLE);
  assign settle_done = measuring && match &&
                       ((state_q == WAIT) ? (SETTLE_CYCLES == 1)
                                          : (match_cnt == MW'(SETTLE_CYCLES - 1)));
  assign timed_out   = measuring && (cnt == CNT_W'(MAX_CYCLES)) && !settle_done;
  assign accept      = (state_q == REPORT) && res.res_ready_i;

  always_comb begin
    state_d       = state_q;
    exp_d         = exp_q;
    first_match_d = first_match_q;
    res_d         = res_q;
    cnt_clr       = 1'b1;
    cnt_inc       = 1'b0;
    mcnt_clr      = 1'b1;
    mcnt_inc      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          exp_d   = expected_i;
          state_d = WAIT;
        end
      end
      WAIT, SETTLE: begin
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b1;
        mcnt_clr = !match;
        mcnt_inc = match;
        if (state_q == WAIT && match) begin
          first_match_d = cnt;
          state_d       = SETTLE;
        end
        if (state_q == SETTLE && !match) state_d = WAIT;
        // Settling on the timeout cycle still counts as a pass.
        if (settle_done) begin
          state_d       = REPORT;
          res_d.delay   = (state_q == WAIT) ? cnt : first_match_q;
          res_d.pass    = 1'b1;
          res_d.timeout = 1'b0;
          res_d.value   = observed_i;
        end else if (timed_out) begin
          state_d       = REPORT;
          res_d.delay   = CNT_W'(MAX_CYCLES);
          res_d.pass    = 1'b0;
          res_d.timeout = 1'b1;
          res_d.value   = observed_i;
        end
      end
      REPORT: begin
        if (accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
    end
  end

  always_ff @(posedge clk) begin
    exp_q         <= exp_d;
    first_match_q <= first_match_d;
  end

  assign busy_o            = (state_q != IDLE);
  assign res.res_valid_o   = (state_q == REPORT);
  assign res.res_delay_o   = res_q.delay;
  assign res.res_pass_o    = res_q.pass;
  assign res.res_timeout_o = res_q.timeout;
  assign res.res_value_o   = res_q.value;

`ifdef DELAY_MON_STATS_EN
  logic [CNT_W-1:0] stat_min_q, stat_min_d, stat_max_q, stat_max_d;

  sat_counter #(.W(16)) u_stat_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(1'b0), .inc_i(accept), .cnt_o(stat_cnt_o)
  );

  sat_counter #(.W(16)) u_stat_fail (
    .clk(clk), .rst_n(rst_n), .clr_i(1'b0), .inc_i(accept && res_q.timeout), .cnt_o(stat_fail_o)
  );

  always_comb begin
    stat_min_d = stat_min_q;
    stat_max_d = stat_max_q;
    if (accept && res_q.pass) begin
      if (res_q.delay < stat_min_q) stat_min_d = res_q.delay;
      if (res_q.delay > stat_max_q) stat_max_d = res_q.delay;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_min_q <= '1;
      stat_max_q <= '0;
    end else begin
      stat_min_q <= stat_min_d;
      stat_max_q <= stat_max_d;
    end
  end

  assign stat_min_o = stat_min_q;
  assign stat_max_o = stat_max_q;
`endif
endmodule

// File: tb/tb_delay_capture_monitor.sv
// Randomized bench for delay_capture_monitor against a run-length reference model.
module tb_delay_capture_monitor;
  import delay_mon_pkg::*;

  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int MAXC = 200;
  localparam int SETL = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start_i = 1'b0;
  logic [DW-1:0] expected_i = '0;
  logic [DW-1:0] observed_i = '0;
  logic          busy_o;
  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] obs [0:255];

  delay_capture_monitor_if #(.DATA_W(DW), .CNT_W(CW)) rif ();

`ifdef DELAY_MON_STATS_EN
  logic [15:0]   stat_cnt_o, stat_fail_o;
  logic [CW-1:0] stat_min_o, stat_max_o;
  int            m_cnt = 0, m_fail = 0, m_min = 255, m_max = 0;
`endif

  delay_capture_monitor #(
    .DATA_W(DW), .CNT_W(CW), .MAX_CYCLES(MAXC), .SETTLE_CYCLES(SETL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(start_i),
    .expected_i(expected_i),
    .observed_i(observed_i),
    .busy_o(busy_o),
    .res(rif)
`ifdef DELAY_MON_STATS_EN
    ,
    .stat_cnt_o(stat_cnt_o),
    .stat_min_o(stat_min_o),
    .stat_max_o(stat_max_o),
    .stat_fail_o(stat_fail_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Result = first cycle ending a run of SETL consecutive matches, if that happens by MAXC.
  task automatic model_run(input logic [DW-1:0] e, output res_t r, output int dcyc);
    int run;
    bit done;
    run = 0;
    done = 0;
    dcyc = MAXC;
    r.delay = CW'(MAXC);
    r.pass = 1'b0;
    r.timeout = 1'b1;
    r.value = obs[MAXC];
    for (int k = 0; k <= MAXC; k++) begin
      if (!done) begin
        run = (obs[k] === e) ? run + 1 : 0;
        if (run >= SETL) begin
          done = 1;
          dcyc = k;
          r.delay = CW'(k - SETL + 1);
          r.pass = 1'b1;
          r.timeout = 1'b0;
          r.value = obs[k];
        end
      end
    end
  endtask

  task automatic fill_noise(input logic [DW-1:0] e);
    for (int k = 0; k < 256; k++) obs[k] = e ^ DW'(1 << $urandom_range(0, DW - 1));
  endtask

  task automatic set_match(input logic [DW-1:0] e, input int from, input int upto);
    for (int k = from; k <= upto; k++) obs[k] = e;
  endtask

  task automatic model_stats_reset();
`ifdef DELAY_MON_STATS_EN
    m_cnt = 0; m_fail = 0; m_min = 255; m_max = 0;
`endif
  endtask

  task automatic run_meas(input logic [DW-1:0] e, input int hold);
    res_t r;
    int dcyc;
    int k;
    model_run(e, r, dcyc);
    @(negedge clk);
    start_i = 1'b1;
    expected_i = e;
    @(negedge clk);
    start_i = 1'b0;
    expected_i = ~e;
    chk("busy_start", busy_o, 1);
    k = 0;
    while (!rif.res_valid_o && k < MAXC + 10) begin
      observed_i = obs[k];
      @(negedge clk);
      k++;
    end
    chk("latency", k, dcyc + 1);
    chk("valid", rif.res_valid_o, 1);
    chk("delay", rif.res_delay_o, r.delay);
    chk("pass", rif.res_pass_o, r.pass);
    chk("timeout", rif.res_timeout_o, r.timeout);
    chk("value", rif.res_value_o, r.value);
    for (int h = 0; h < hold; h++) begin
      start_i = (h == hold / 2);
      observed_i = DW'($urandom);
      @(negedge clk);
      chk("hold_valid", rif.res_valid_o, 1);
      chk("hold_delay", rif.res_delay_o, r.delay);
      chk("hold_value", rif.res_value_o, r.value);
    end
    start_i = 1'b1;
    rif.res_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    rif.res_ready_i = 1'b0;
    chk("valid_drop", rif.res_valid_o, 0);
    chk("busy_idle", busy_o, 0);
`ifdef DELAY_MON_STATS_EN
    if (m_cnt < 65535) m_cnt++;
    if (r.timeout && m_fail < 65535) m_fail++;
    if (r.pass) begin
      if (int'(r.delay) < m_min) m_min = int'(r.delay);
      if (int'(r.delay) > m_max) m_max = int'(r.delay);
    end
`endif
  endtask

  initial begin
    logic [DW-1:0] e;
    int mode;
    rif.res_ready_i = 1'b0;
    #1 rst_n = 1'b0;
    #10;
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", rif.res_valid_o, 0);
    chk("rst_delay", rif.res_delay_o, 0);
    chk("rst_pass", rif.res_pass_o, 0);
    chk("rst_timeout", rif.res_timeout_o, 0);
    chk("rst_value", rif.res_value_o, 0);
`ifdef DELAY_MON_STATS_EN
    chk("rst_stat_min", stat_min_o, 8'hFF);
    chk("rst_stat_cnt", stat_cnt_o, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    fill_noise(8'h2A); set_match(8'h2A, 3, 255);
    run_meas(8'h2A, 0);

    fill_noise(8'h2A); obs[2] = 8'h2A; set_match(8'h2A, 5, 255);
    run_meas(8'h2A, 1);

    fill_noise(8'h2A);
    run_meas(8'h2A, 0);

    fill_noise(8'h2A); set_match(8'h2A, 199, 255);
    run_meas(8'h2A, 0);

    fill_noise(8'h2A); set_match(8'h2A, 200, 255);
    run_meas(8'h2A, 0);

    fill_noise(8'h2A); set_match(8'h2A, 3, 255);
    run_meas(8'h2A, 10);

    @(negedge clk);
    start_i = 1'b1;
    expected_i = 8'h55;
    @(negedge clk);
    start_i = 1'b0;
    observed_i = 8'h00;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", busy_o, 0);
    chk("async_valid", rif.res_valid_o, 0);
    model_stats_reset();
    @(negedge clk);
    rst_n = 1'b1;
    fill_noise(8'h2A); set_match(8'h2A, 3, 255);
    run_meas(8'h2A, 0);

    for (int n = 0; n < 20; n++) begin
      e = DW'($urandom);
      mode = $urandom_range(0, 2);
      fill_noise(e);
      if (mode == 0) set_match(e, $urandom_range(0, 30), 255);
      else begin
        for (int j = 0; j < 6; j++) obs[$urandom_range(0, 40)] = e;
        if (mode == 1) set_match(e, $urandom_range(40, 60), 255);
      end
      run_meas(e, $urandom_range(0, 4));
    end

`ifdef DELAY_MON_STATS_EN
    chk("stat_cnt", stat_cnt_o, m_cnt);
    chk("stat_fail", stat_fail_o, m_fail);
    chk("stat_min", stat_min_o, m_min);
    chk("stat_max", stat_max_o, m_max);
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_stats_reset();
    fill_noise(8'h11); set_match(8'h11, 3, 255);
    run_meas(8'h11, 0);
    fill_noise(8'h11); set_match(8'h11, 7, 255);
    run_meas(8'h11, 0);
    fill_noise(8'h11);
    run_meas(8'h11, 0);
    chk("t6_stat_cnt", stat_cnt_o, 3);
    chk("t6_stat_min", stat_min_o, 3);
    chk("t6_stat_max", stat_max_o, 7);
    chk("t6_stat_fail", stat_fail_o, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
